// File: rtl/boot_ctrl_pkg.sv
// Shared definitions for the boot/reload controller: datapath width,
// FSM state encoding and the header sanity check.
package boot_ctrl_pkg;

    localparam int CPU_WIDTH     = 32;
    localparam int BOOT_ST_WIDTH = 3;

    typedef enum logic [BOOT_ST_WIDTH-1:0] {
        BOOT_HDR  = 3'd0,
        BOOT_LOAD = 3'd1,
        BOOT_REL  = 3'd2,
        BOOT_RUN  = 3'd3,
        BOOT_ERR  = 3'd4
    } boot_st_e;

    // A word count of zero or one larger than the memory is unloadable.
    function automatic logic hdr_bad(input logic [CPU_WIDTH-1:0] n, input int depth);
        return (n == '0) || (n > CPU_WIDTH'(depth));
    endfunction

endpackage

// File: rtl/boot_ctrl_byte_packer.sv
// Little-endian byte-to-word packer. The first byte of a group ends up in
// bits [7:0]. The completed word is presented combinationally together with
// word_done on the cycle the 4th byte is pushed, so the caller registers it
// on the same edge that accepts that byte.
module byte_packer
    import boot_ctrl_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr,
    input  logic                 push,
    input  logic [7:0]           byte_i,
    output logic [CPU_WIDTH-1:0] word,
    output logic                 word_done
);

    logic [1:0]           cnt_q;
    logic [CPU_WIDTH-1:0] sh_q;

    // New bytes enter at the top and shift down, so after four pushes the
    // first byte sits in the low lane.
    assign word      = {byte_i, sh_q[CPU_WIDTH-1:8]};
    assign word_done = push && (cnt_q == 2'd3);

    // Byte counter and shift register; clr discards any partial word.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt_q <= 2'd0;
            sh_q  <= '0;
        end else if (push) begin
            cnt_q <= cnt_q + 2'd1;
            sh_q  <= word;
        end
    end

endmodule

// File: rtl/boot_ctrl.sv
// Boot/reload controller: holds the core in reset, receives a length-prefixed
// byte image, writes it into instruction memory word by word, then releases
// the core after a fixed hold interval. A reload request in RUN restarts it.
module boot_ctrl
    import boot_ctrl_pkg::*;
#(
    parameter int IMEM_DEPTH = 256,
    parameter int AW         = 8,
    parameter int RST_HOLD   = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx_valid,
    input  logic [7:0]           rx_data,
    output logic                 rx_ready,
    input  logic                 boot_req,
    output logic                 imem_we,
    output logic [AW-1:0]        imem_waddr,
    output logic [CPU_WIDTH-1:0] imem_wdata,
    output logic                 core_rstn,
    output logic                 busy,
    output logic                 err
);

    // Wide enough to hold the word count itself (up to IMEM_DEPTH).
    localparam int IW = $clog2(IMEM_DEPTH + 1);

    boot_st_e             state_q, state_d;
    logic [IW-1:0]        idx_q, idx_d;
    logic [IW-1:0]        nw_q, nw_d;
    logic [7:0]           hold_q, hold_d;
    logic                 we_q, we_d;
    logic [AW-1:0]        waddr_q, waddr_d;
    logic [CPU_WIDTH-1:0] wdata_q, wdata_d;
    logic                 rstn_q, rstn_d;
    logic                 busy_q, busy_d;
    logic                 err_q, err_d;

    logic                 accept;
    logic                 pk_clr;
    logic [CPU_WIDTH-1:0] pk_word;
    logic                 pk_done;

    assign rx_ready = (state_q == BOOT_HDR) || (state_q == BOOT_LOAD);
    assign accept   = rx_valid && rx_ready;
    // Any stray partial word is dropped while the core runs, so a reload
    // always starts byte-aligned on the header.
    assign pk_clr   = (state_q == BOOT_RUN);

    byte_packer u_packer (
        .clk       (clk),
        .rst       (rst),
        .clr       (pk_clr),
        .push      (accept),
        .byte_i    (rx_data),
        .word      (pk_word),
        .word_done (pk_done)
    );

    // Next-state and next-output logic for the load sequence.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        nw_d    = nw_q;
        hold_d  = hold_q;
        we_d    = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;

        case (state_q)
            BOOT_HDR: begin
                if (pk_done) begin
                    if (hdr_bad(pk_word, IMEM_DEPTH)) begin
                        state_d = BOOT_ERR;
                    end else begin
                        state_d = BOOT_LOAD;
                        idx_d   = '0;
                        nw_d    = pk_word[IW-1:0];
                    end
                end
            end
            BOOT_LOAD: begin
                if (pk_done) begin
                    we_d    = 1'b1;
                    waddr_d = AW'(idx_q);
                    wdata_d = pk_word;
                    idx_d   = idx_q + IW'(1);
                    if (idx_q == nw_q - IW'(1)) begin
                        state_d = BOOT_REL;
                        hold_d  = 8'd0;
                    end
                end
            end
            BOOT_REL: begin
                if (hold_q == 8'(RST_HOLD - 1)) begin
                    state_d = BOOT_RUN;
                end else begin
                    hold_d = hold_q + 8'd1;
                end
            end
            BOOT_RUN: begin
                if (boot_req) begin
                    state_d = BOOT_HDR;
                end
            end
            BOOT_ERR: begin
                state_d = BOOT_ERR;
            end
            default: begin
                state_d = BOOT_HDR;
            end
        endcase

        // Status outputs are registered from the next state so they line
        // up with the state they describe.
        rstn_d = (state_d == BOOT_RUN);
        busy_d = (state_d == BOOT_HDR) || (state_d == BOOT_LOAD) || (state_d == BOOT_REL);
        err_d  = err_q || (state_d == BOOT_ERR);
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= BOOT_HDR;
            idx_q   <= '0;
            nw_q    <= '0;
            hold_q  <= 8'd0;
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
            rstn_q  <= 1'b0;
            busy_q  <= 1'b1;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            nw_q    <= nw_d;
            hold_q  <= hold_d;
            we_q    <= we_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            rstn_q  <= rstn_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
        end
    end

    assign imem_we    = we_q;
    assign imem_waddr = waddr_q;
    assign imem_wdata = wdata_q;
    assign core_rstn  = rstn_q;
    assign busy       = busy_q;
    assign err        = err_q;

endmodule

// File: tb/tb_boot_ctrl.sv
// Directed bench for boot_ctrl. Stimulus builds byte images and pushes the
// expected memory writes into a scoreboard queue; a monitor pops and
// compares on every write strobe.
module tb_boot_ctrl;

    localparam int IMEM_DEPTH = 256;
    localparam int AW         = 8;
    localparam int RST_HOLD   = 4;

    typedef struct {
        logic [AW-1:0] a;
        logic [31:0]   d;
    } wr_t;

    logic          clk;
    logic          rst;
    logic          rx_valid;
    logic [7:0]    rx_data;
    logic          rx_ready;
    logic          boot_req;
    logic          imem_we;
    logic [AW-1:0] imem_waddr;
    logic [31:0]   imem_wdata;
    logic          core_rstn;
    logic          busy;
    logic          err;

    int            checks;
    int            errors;
    int            wr_cnt;
    logic [AW-1:0] last_addr;
    wr_t           exp_q[$];
    logic [7:0]    img[$];

    boot_ctrl #(
        .IMEM_DEPTH (IMEM_DEPTH),
        .AW         (AW),
        .RST_HOLD   (RST_HOLD)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rx_valid   (rx_valid),
        .rx_data    (rx_data),
        .rx_ready   (rx_ready),
        .boot_req   (boot_req),
        .imem_we    (imem_we),
        .imem_waddr (imem_waddr),
        .imem_wdata (imem_wdata),
        .core_rstn  (core_rstn),
        .busy       (busy),
        .err        (err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every write strobe must match the oldest expected write.
    always @(negedge clk) begin
        if (imem_we === 1'b1) begin
            wr_cnt++;
            last_addr = imem_waddr;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write addr=%0h data=%0h", imem_waddr, imem_wdata);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                chk("wr_addr", 32'(imem_waddr), 32'(e.a));
                chk("wr_data", imem_wdata, e.d);
            end
        end
    end

    task automatic add_hdr(input logic [31:0] n);
        img.delete();
        for (int i = 0; i < 4; i++) img.push_back(n[8*i +: 8]);
    endtask

    task automatic add_word(input logic [AW-1:0] a, input logic [31:0] w, input bit expect_wr);
        wr_t e;
        for (int i = 0; i < 4; i++) img.push_back(w[8*i +: 8]);
        if (expect_wr) begin
            e.a = a;
            e.d = w;
            exp_q.push_back(e);
        end
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        rx_valid = 1'b1;
        rx_data  = b;
        while (rx_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (rx_ready !== 1'b1) chk("rx_ready_timeout", 32'(rx_ready), 32'd1);
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic send_img(input int gapmax);
        for (int i = 0; i < img.size(); i++) begin
            if (gapmax > 0) repeat ($urandom_range(0, gapmax)) @(negedge clk);
            send_byte(img[i]);
        end
    endtask

    // Entered at the negedge of the first REL cycle (last write strobe).
    task automatic check_release(input bit toggle);
        int n;
        n = 0;
        chk("rel_strobe", 32'(imem_we), 32'd1);
        while (core_rstn !== 1'b1 && n < 50) begin
            chk("rel_busy", 32'(busy), 32'd1);
            if (toggle) begin
                rx_valid = ~rx_valid;
                rx_data  = 8'h55;
            end
            @(negedge clk);
            n++;
        end
        chk("rel_len", 32'(n), 32'(RST_HOLD));
        chk("run_busy", 32'(busy), 32'd0);
        chk("run_rx_ready", 32'(rx_ready), 32'd0);
        if (toggle) begin
            repeat (4) begin
                rx_valid = ~rx_valid;
                rx_data  = 8'hAA;
                @(negedge clk);
            end
        end
        rx_valid = 1'b0;
        chk("run_rstn_hold", 32'(core_rstn), 32'd1);
        chk("sb_empty", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        rx_valid = 1'b0;
        boot_req = 1'b0;
        @(negedge clk);
        chk("rst_we", 32'(imem_we), 32'd0);
        chk("rst_waddr", 32'(imem_waddr), 32'd0);
        chk("rst_wdata", imem_wdata, 32'd0);
        chk("rst_rstn", 32'(core_rstn), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_busy", 32'(busy), 32'd1);
        rst = 1'b0;
        chk("rst_rx_ready", 32'(rx_ready), 32'd1);
    endtask

    task automatic bad_hdr(input logic [31:0] n);
        int w0;
        w0 = wr_cnt;
        add_hdr(n);
        send_img(0);
        chk("bad_err", 32'(err), 32'd1);
        chk("bad_rstn", 32'(core_rstn), 32'd0);
        chk("bad_rx_ready", 32'(rx_ready), 32'd0);
        chk("bad_busy", 32'(busy), 32'd0);
        rx_valid = 1'b1;
        rx_data  = 8'h13;
        repeat (6) @(negedge clk);
        rx_valid = 1'b0;
        chk("bad_err_sticky", 32'(err), 32'd1);
        chk("bad_rstn_stay", 32'(core_rstn), 32'd0);
        chk("bad_no_write", 32'(wr_cnt), 32'(w0));
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        wr_cnt   = 0;
        rst      = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        boot_req = 1'b0;
        @(negedge clk);
        do_reset();

        // Normal back-to-back load.
        add_hdr(32'd2);
        add_word(8'd0, 32'h0010_0513, 1'b1);
        add_word(8'd1, 32'h0020_0593, 1'b1);
        send_img(0);
        check_release(1'b0);

        // Reload with a one-word image.
        boot_req = 1'b1;
        @(negedge clk);
        boot_req = 1'b0;
        chk("reload_rstn", 32'(core_rstn), 32'd0);
        chk("reload_rx_ready", 32'(rx_ready), 32'd1);
        chk("reload_busy", 32'(busy), 32'd1);
        add_hdr(32'd1);
        add_word(8'd0, 32'hDEAD_BEEF, 1'b1);
        send_img(0);
        check_release(1'b0);

        // Gapped stream; rx_valid wiggles while not ready.
        do_reset();
        add_hdr(32'd2);
        add_word(8'd0, 32'h0010_0513, 1'b1);
        add_word(8'd1, 32'h0020_0593, 1'b1);
        send_img(5);
        check_release(1'b1);

        // Reset after 6 payload bytes: only the first word is written.
        do_reset();
        add_hdr(32'd2);
        add_word(8'd0, 32'h1122_3344, 1'b1);
        img.push_back(8'h77);
        img.push_back(8'h66);
        send_img(0);
        chk("midrst_sb", 32'(exp_q.size()), 32'd0);
        do_reset();
        add_hdr(32'd2);
        add_word(8'd0, 32'hCAFE_0001, 1'b1);
        add_word(8'd1, 32'hCAFE_0002, 1'b1);
        send_img(0);
        check_release(1'b0);

        // Bad headers.
        do_reset();
        bad_hdr(32'd0);
        do_reset();
        bad_hdr(32'd257);

        // Full memory image.
        do_reset();
        add_hdr(32'(IMEM_DEPTH));
        for (int i = 0; i < IMEM_DEPTH; i++) add_word(AW'(i), 32'hC000_0000 | 32'(i), 1'b1);
        send_img(0);
        check_release(1'b0);
        chk("full_last_addr", 32'(last_addr), 32'(IMEM_DEPTH - 1));
        repeat (5) @(negedge clk);
        chk("full_sb_final", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
